// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults for the data-memory arbiter slice.
//   N_CORES  - number of requesting cores (2..8)
//   ADDR_W   - data-memory address width
//   WDATA_W  - write data width
//   RDATA_W  - read data width
//   CID_W    - width of a core index / round-robin pointer
package dmem_pkg;

    localparam int N_CORES = 4;
    localparam int ADDR_W  = 8;
    localparam int WDATA_W = 16;
    localparam int RDATA_W = 8;
    localparam int CID_W   = $clog2(N_CORES);

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search.
//   eligible_i - per-core eligibility mask
//   ptr_i      - highest-priority core index this cycle
//   found_o    - at least one core is eligible
//   winner_o   - index of the first eligible core at or after ptr_i (wrapping)
module rr_pick
    import dmem_pkg::*;
#(
    parameter int N     = N_CORES,
    parameter int PTR_W = CID_W
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             found_o,
    output logic [PTR_W-1:0] winner_o
);

    localparam logic [PTR_W:0] NUM = (PTR_W + 1)'(N);

    logic [2*N-1:0]   doubled;
    logic [N-1:0]     rotated;
    logic [PTR_W-1:0] offset;
    logic [PTR_W:0]   sum;

    // Concatenating the mask with itself lets a plain right shift rotate it,
    // so bit 0 of rotated is core ptr_i, bit 1 is ptr_i+1 and so on.
    assign doubled = {eligible_i, eligible_i};
    assign rotated = N'(doubled >> ptr_i);

    // Lowest set bit of the rotated mask is the closest eligible core.
    always_comb begin
        found_o = 1'b0;
        offset  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found_o = 1'b1;
                offset  = PTR_W'(i);
            end
        end
    end

    // Undo the rotation: winner = (ptr + offset) mod N.
    assign sum      = {1'b0, ptr_i} + {1'b0, offset};
    assign winner_o = (sum >= NUM) ? PTR_W'(sum - NUM) : PTR_W'(sum);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port synchronous
// data memory between N_CORES cores.
//   clk, rst_n            - clock, asynchronous active-low reset
//   req/req_we            - per-core request and write flag (held until gnt)
//   req_addr/req_wdata    - per-core address / write data, packed by core
//   gnt                   - one-hot 1-cycle grant pulse
//   rvalid/rdata          - one-hot read-return pulse and read data
//   mem_en/mem_we         - memory strobe and write enable
//   mem_addr/mem_wdata    - memory command address and write data
//   mem_rdata             - memory read data, valid the cycle after the command
module dmem_arbiter #(
    parameter int N_CORES = dmem_pkg::N_CORES,
    parameter int ADDR_W  = dmem_pkg::ADDR_W,
    parameter int WDATA_W = dmem_pkg::WDATA_W,
    parameter int RDATA_W = dmem_pkg::RDATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CORES-1:0]           req,
    input  logic [N_CORES-1:0]           req_we,
    input  logic [N_CORES*ADDR_W-1:0]    req_addr,
    input  logic [N_CORES*WDATA_W-1:0]   req_wdata,
    output logic [N_CORES-1:0]           gnt,
    output logic [N_CORES-1:0]           rvalid,
    output logic [RDATA_W-1:0]           rdata,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WDATA_W-1:0]           mem_wdata,
    input  logic [RDATA_W-1:0]           mem_rdata
);

    localparam int CID_W = $clog2(N_CORES);
    localparam logic [CID_W-1:0] LAST_CORE = CID_W'(N_CORES - 1);

    logic [N_CORES-1:0] eligible;
    logic               found;
    logic [CID_W-1:0]   winner;

    logic [N_CORES-1:0] gnt_q,       gnt_d;
    logic               mem_en_q,    mem_en_d;
    logic               mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [WDATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CID_W-1:0]   ptr_q,       ptr_d;
    logic [CID_W-1:0]   cid_q,       cid_d;
    logic               s1_valid_q,  s1_valid_d;
    logic [CID_W-1:0]   s1_id_q,     s1_id_d;
    logic               s2_valid_q,  s2_valid_d;
    logic [CID_W-1:0]   s2_id_q,     s2_id_d;
    logic [RDATA_W-1:0] rdata_q,     rdata_d;

    // A core granted this cycle still holds req, so it must sit out the
    // next arbitration or it would be granted twice for one request.
    assign eligible = req & ~gnt_q;

    rr_pick #(
        .N     (N_CORES),
        .PTR_W (CID_W)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .found_o    (found),
        .winner_o   (winner)
    );

    // cid_q remembers which core owns the command currently on the memory
    // port; stage 1 picks it up together with the read flag one cycle later,
    // which is when mem_rdata for that command becomes valid.
    always_comb begin
        gnt_d       = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ptr_d       = ptr_q;
        cid_d       = cid_q;

        if (found) begin
            gnt_d       = N_CORES'(1) << winner;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we[winner];
            mem_addr_d  = req_addr[winner*ADDR_W +: ADDR_W];
            mem_wdata_d = req_wdata[winner*WDATA_W +: WDATA_W];
            ptr_d       = (winner == LAST_CORE) ? '0 : winner + CID_W'(1);
            cid_d       = winner;
        end

        s1_valid_d = mem_en_q & ~mem_we_q;
        s1_id_d    = cid_q;
        s2_valid_d = s1_valid_q;
        s2_id_d    = s1_id_q;
        rdata_d    = s1_valid_q ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ptr_q       <= '0;
            cid_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            rdata_q     <= '0;
        end else begin
            gnt_q       <= gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ptr_q       <= ptr_d;
            cid_q       <= cid_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign rvalid    = s2_valid_q ? (N_CORES'(1) << s2_id_q) : '0;

endmodule
